// File: rtl/risc_v_id_ex.sv
// risc_v_id_ex -- ID/EX pipeline boundary of the 5-stage RISC-V core.
//
// Decodes main control from the ID-stage opcode and registers operands,
// function fields, register indices and control into the EX stage.
// Detects load-use hazards against the instruction currently in EX and
// stalls PC / IF-ID for one cycle, inserting a bubble. A taken branch
// (PCSrc) flushes IF/ID and also bubbles EX; flush wins over a stall.
// STALL_COUNT is a saturating count of hazard-stall cycles.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   PCSrc                 taken branch resolved downstream (flush request)
//   *_ID                  decoded fields of the instruction in ID
//   PC_write, IF_ID_write combinational upstream enables (0 = stall)
//   IF_ID_flush           combinational IF/ID clear (follows PCSrc)
//   *_EX                  registered operands, fields and control
//   STALL_COUNT           saturating hazard-stall cycle counter
module risc_v_id_ex #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrc,
  input  logic [31:0]        PC_ID,
  input  logic [31:0]        IMM_ID,
  input  logic [31:0]        REG_DATA1_ID,
  input  logic [31:0]        REG_DATA2_ID,
  input  logic [2:0]         FUNCT3_ID,
  input  logic [6:0]         FUNCT7_ID,
  input  logic [6:0]         OPCODE_ID,
  input  logic [4:0]         RD_ID,
  input  logic [4:0]         RS1_ID,
  input  logic [4:0]         RS2_ID,
  output logic               PC_write,
  output logic               IF_ID_write,
  output logic               IF_ID_flush,
  output logic [31:0]        PC_EX,
  output logic [31:0]        IMM_EX,
  output logic [31:0]        REG_DATA1_EX,
  output logic [31:0]        REG_DATA2_EX,
  output logic [2:0]         FUNCT3_EX,
  output logic [6:0]         FUNCT7_EX,
  output logic [4:0]         RD_EX,
  output logic [4:0]         RS1_EX,
  output logic [4:0]         RS2_EX,
  output logic               RegWrite_EX,
  output logic               MemtoReg_EX,
  output logic               MemRead_EX,
  output logic               MemWrite_EX,
  output logic               ALUSrc_EX,
  output logic               Branch_EX,
  output logic [1:0]         ALUOp_EX,
  output logic [COUNT_W-1:0] STALL_COUNT
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I_ALU  = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  // Main control decode
  ctrl_t ctrl_dec;
  logic  uses_rs2;

  always_comb begin
    ctrl_dec = '0;
    uses_rs2 = 1'b0;
    case (OPCODE_ID)
      OP_R: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = 2'b10;
        uses_rs2           = 1'b1;
      end
      OP_I_ALU: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.alu_op    = 2'b10;
      end
      OP_LOAD: begin
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.alu_op     = 2'b00;
      end
      OP_STORE: begin
        ctrl_dec.mem_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.alu_op    = 2'b00;
        uses_rs2           = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_dec.branch = 1'b1;
        ctrl_dec.alu_op = 2'b01;
        uses_rs2        = 1'b1;
      end
      default: begin
        ctrl_dec = '0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  // Pipeline state
  logic [31:0]        pc_q,    pc_d;
  logic [31:0]        imm_q,   imm_d;
  logic [31:0]        data1_q, data1_d;
  logic [31:0]        data2_q, data2_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [6:0]         funct7_q, funct7_d;
  logic [4:0]         rd_q,    rd_d;
  logic [4:0]         rs1_q,   rs1_d;
  logic [4:0]         rs2_q,   rs2_d;
  ctrl_t              ctrl_q,  ctrl_d;
  logic [COUNT_W-1:0] stall_count_q, stall_count_d;

  // Hazard detection against the load currently in EX; x0 never hazards.
  logic hazard;
  logic stall;
  logic bubble;

  always_comb begin
    hazard = ctrl_q.mem_read && (rd_q != 5'd0) &&
             ((rd_q == RS1_ID) || (uses_rs2 && (rd_q == RS2_ID)));
    // Flush takes priority: a hazard under PCSrc is not a stall.
    stall  = hazard && !PCSrc;
    bubble = hazard || PCSrc;
  end

  always_comb begin
    pc_d     = PC_ID;
    imm_d    = IMM_ID;
    data1_d  = REG_DATA1_ID;
    data2_d  = REG_DATA2_ID;
    funct3_d = FUNCT3_ID;
    funct7_d = FUNCT7_ID;
    rd_d     = RD_ID;
    rs1_d    = RS1_ID;
    rs2_d    = RS2_ID;
    ctrl_d   = bubble ? '0 : ctrl_dec;

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= '0;
      imm_q         <= '0;
      data1_q       <= '0;
      data2_q       <= '0;
      funct3_q      <= '0;
      funct7_q      <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      ctrl_q        <= '0;
      stall_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      data1_q       <= data1_d;
      data2_q       <= data2_d;
      funct3_q      <= funct3_d;
      funct7_q      <= funct7_d;
      rd_q          <= rd_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      ctrl_q        <= ctrl_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Upstream control; flush is held low while reset is asserted.
  always_comb begin
    PC_write    = !stall;
    IF_ID_write = !stall;
    IF_ID_flush = PCSrc && !reset;
  end

  always_comb begin
    PC_EX        = pc_q;
    IMM_EX       = imm_q;
    REG_DATA1_EX = data1_q;
    REG_DATA2_EX = data2_q;
    FUNCT3_EX    = funct3_q;
    FUNCT7_EX    = funct7_q;
    RD_EX        = rd_q;
    RS1_EX       = rs1_q;
    RS2_EX       = rs2_q;
    RegWrite_EX  = ctrl_q.reg_write;
    MemtoReg_EX  = ctrl_q.mem_to_reg;
    MemRead_EX   = ctrl_q.mem_read;
    MemWrite_EX  = ctrl_q.mem_write;
    ALUSrc_EX    = ctrl_q.alu_src;
    Branch_EX    = ctrl_q.branch;
    ALUOp_EX     = ctrl_q.alu_op;
    STALL_COUNT  = stall_count_q;
  end

endmodule

// File: tb/tb_risc_v_id_ex.sv
// Scoreboard bench for risc_v_id_ex: the driver computes expected upstream
// enables and next EX state from a behavioural model and queues them; the
// monitor pops each entry, checks enables before the edge and EX state after.
module tb_risc_v_id_ex;

  localparam int unsigned CW = 2;
  localparam int unsigned CMAX = (1 << CW) - 1;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;
  localparam logic [6:0] OPC_XX = 7'b1111111;

  logic clk = 1'b0;
  logic reset;
  logic PCSrc;
  logic [31:0] PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID;
  logic [2:0]  FUNCT3_ID;
  logic [6:0]  FUNCT7_ID, OPCODE_ID;
  logic [4:0]  RD_ID, RS1_ID, RS2_ID;
  logic PC_write, IF_ID_write, IF_ID_flush;
  logic [31:0] PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX;
  logic [2:0]  FUNCT3_EX;
  logic [6:0]  FUNCT7_EX;
  logic [4:0]  RD_EX, RS1_EX, RS2_EX;
  logic RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX, Branch_EX;
  logic [1:0]  ALUOp_EX;
  logic [CW-1:0] STALL_COUNT;

  risc_v_id_ex #(.COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc),
    .PC_ID(PC_ID), .IMM_ID(IMM_ID),
    .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID),
    .FUNCT3_ID(FUNCT3_ID), .FUNCT7_ID(FUNCT7_ID), .OPCODE_ID(OPCODE_ID),
    .RD_ID(RD_ID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .PC_EX(PC_EX), .IMM_EX(IMM_EX),
    .REG_DATA1_EX(REG_DATA1_EX), .REG_DATA2_EX(REG_DATA2_EX),
    .FUNCT3_EX(FUNCT3_EX), .FUNCT7_EX(FUNCT7_EX),
    .RD_EX(RD_EX), .RS1_EX(RS1_EX), .RS2_EX(RS2_EX),
    .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX),
    .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
    .ALUSrc_EX(ALUSrc_EX), .Branch_EX(Branch_EX),
    .ALUOp_EX(ALUOp_EX), .STALL_COUNT(STALL_COUNT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pcw;
    logic        flush;
    logic [31:0] pc, imm, d1, d2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic        rw, m2r, mr, mw, as, br;
    logic [1:0]  aluop;
    int unsigned cnt;
  } ex_t;

  ex_t sb[$];
  ex_t m;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ex_t zero_state();
    ex_t z;
    z.pcw = 1'b1; z.flush = 1'b0;
    z.pc = '0; z.imm = '0; z.d1 = '0; z.d2 = '0;
    z.f3 = '0; z.f7 = '0; z.rd = '0; z.rs1 = '0; z.rs2 = '0;
    z.rw = 1'b0; z.m2r = 1'b0; z.mr = 1'b0; z.mw = 1'b0; z.as = 1'b0; z.br = 1'b0;
    z.aluop = '0; z.cnt = 0;
    return z;
  endfunction

  task automatic drive_in(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                          input logic pcsrc);
    OPCODE_ID    = op;
    RD_ID        = rd;
    RS1_ID       = rs1;
    RS2_ID       = rs2;
    PCSrc        = pcsrc;
    PC_ID        = $urandom;
    IMM_ID       = $urandom;
    REG_DATA1_ID = $urandom;
    REG_DATA2_ID = $urandom;
    FUNCT3_ID    = 3'($urandom);
    FUNCT7_ID    = 7'($urandom);
  endtask

  // Reference model: one instruction presented in ID for one cycle.
  task automatic step(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                      input logic pcsrc);
    ex_t e;
    bit is_r, is_i, is_ld, is_st, is_br, reads_rs2, load_use;
    drive_in(op, rd, rs1, rs2, pcsrc);
    is_r  = (op == OPC_R);
    is_i  = (op == OPC_I);
    is_ld = (op == OPC_LD);
    is_st = (op == OPC_ST);
    is_br = (op == OPC_BR);
    reads_rs2 = is_r || is_st || is_br;
    load_use = m.mr && (m.rd != 0) && ((m.rd == rs1) || (reads_rs2 && (m.rd == rs2)));

    e.pcw   = !(load_use && !pcsrc);
    e.flush = pcsrc;
    e.pc = PC_ID; e.imm = IMM_ID; e.d1 = REG_DATA1_ID; e.d2 = REG_DATA2_ID;
    e.f3 = FUNCT3_ID; e.f7 = FUNCT7_ID; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    if (load_use || pcsrc) begin
      e.rw = 0; e.m2r = 0; e.mr = 0; e.mw = 0; e.as = 0; e.br = 0; e.aluop = 0;
    end else begin
      e.rw    = is_r || is_i || is_ld;
      e.m2r   = is_ld;
      e.mr    = is_ld;
      e.mw    = is_st;
      e.as    = is_i || is_ld || is_st;
      e.br    = is_br;
      e.aluop = (is_r || is_i) ? 2'b10 : (is_br ? 2'b01 : 2'b00);
    end
    e.cnt = m.cnt;
    if (load_use && !pcsrc && m.cnt < CMAX) e.cnt = m.cnt + 1;
    sb.push_back(e);
    m = e;
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc_write"},    PC_write, 1'b1);
    check({tag, "_if_id_write"}, IF_ID_write, 1'b1);
    check({tag, "_if_id_flush"}, IF_ID_flush, 1'b0);
    check({tag, "_stall_count"}, STALL_COUNT, 0);
    check({tag, "_pc_ex"},       PC_EX, 0);
    check({tag, "_rd_ex"},       RD_EX, 0);
    check({tag, "_ctrl_ex"},
          {RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX, Branch_EX, ALUOp_EX}, 0);
  endtask

  // Monitor: enables checked at the falling edge, EX state just after rising edge.
  initial begin
    ex_t r;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        r = sb.pop_front();
        check("pc_write",    PC_write,    r.pcw);
        check("if_id_write", IF_ID_write, r.pcw);
        check("if_id_flush", IF_ID_flush, r.flush);
        @(posedge clk);
        #1;
        check("pc_ex",        PC_EX,        r.pc);
        check("imm_ex",       IMM_EX,       r.imm);
        check("reg_data1_ex", REG_DATA1_EX, r.d1);
        check("reg_data2_ex", REG_DATA2_EX, r.d2);
        check("funct3_ex",    FUNCT3_EX,    r.f3);
        check("funct7_ex",    FUNCT7_EX,    r.f7);
        check("rd_ex",        RD_EX,        r.rd);
        check("rs1_ex",       RS1_EX,       r.rs1);
        check("rs2_ex",       RS2_EX,       r.rs2);
        check("regwrite_ex",  RegWrite_EX,  r.rw);
        check("memtoreg_ex",  MemtoReg_EX,  r.m2r);
        check("memread_ex",   MemRead_EX,   r.mr);
        check("memwrite_ex",  MemWrite_EX,  r.mw);
        check("alusrc_ex",    ALUSrc_EX,    r.as);
        check("branch_ex",    Branch_EX,    r.br);
        check("aluop_ex",     ALUOp_EX,     r.aluop);
        check("stall_count",  STALL_COUNT,  r.cnt);
      end
    end
  end

  initial begin
    logic [6:0] ops [6];
    logic [6:0] op;
    ops[0] = OPC_R; ops[1] = OPC_I; ops[2] = OPC_LD;
    ops[3] = OPC_ST; ops[4] = OPC_BR; ops[5] = OPC_XX;

    reset = 1'b1;
    drive_in(OPC_LD, 5'd5, 5'd5, 5'd5, 1'b1);
    #3;
    check_reset_state("por");
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    m = zero_state();

    // Decode sweep
    step(OPC_R,  5'd1, 5'd2, 5'd3, 1'b0);
    step(OPC_I,  5'd2, 5'd3, 5'd4, 1'b0);
    step(OPC_ST, 5'd0, 5'd1, 5'd2, 1'b0);
    step(OPC_BR, 5'd0, 5'd1, 5'd2, 1'b0);
    step(OPC_XX, 5'd3, 5'd4, 5'd5, 1'b0);
    step(OPC_LD, 5'd4, 5'd1, 5'd2, 1'b0);
    step(OPC_I,  5'd6, 5'd7, 5'd1, 1'b0);

    // Load-use stall: lw x5 ; add x6,x5,x1 (held one extra cycle)
    step(OPC_LD, 5'd5, 5'd1, 5'd0, 1'b0);
    step(OPC_R,  5'd6, 5'd5, 5'd1, 1'b0);
    step(OPC_R,  5'd6, 5'd5, 5'd1, 1'b0);
    step(OPC_I,  5'd1, 5'd2, 5'd0, 1'b0);

    // No false hazard: x0 destination, and I-type rs2 field ignored
    step(OPC_LD, 5'd0, 5'd1, 5'd2, 1'b0);
    step(OPC_R,  5'd6, 5'd0, 5'd0, 1'b0);
    step(OPC_LD, 5'd5, 5'd1, 5'd2, 1'b0);
    step(OPC_I,  5'd6, 5'd7, 5'd5, 1'b0);

    // Flush priority over a load-use hazard
    step(OPC_LD, 5'd5, 5'd1, 5'd2, 1'b0);
    step(OPC_R,  5'd6, 5'd5, 5'd1, 1'b1);
    step(OPC_I,  5'd1, 5'd2, 5'd0, 1'b0);

    // Reset asserted mid-stall, checked without waiting for a clock edge
    step(OPC_LD, 5'd5, 5'd1, 5'd2, 1'b0);
    drive_in(OPC_R, 5'd6, 5'd5, 5'd1, 1'b0);
    #1;
    check("stall_before_reset", PC_write, 1'b0);
    reset = 1'b1;
    #1;
    check_reset_state("midrun");
    @(posedge clk);
    #2;
    reset = 1'b0;
    m = zero_state();

    // Saturation: five stalls with a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      step(OPC_LD, 5'd5, 5'd1, 5'd2, 1'b0);
      step(OPC_R,  5'd6, 5'd5, 5'd1, 1'b0);
      step(OPC_R,  5'd6, 5'd5, 5'd1, 1'b0);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 6);
      op = (sel == 6) ? 7'($urandom) : ops[sel];
      step(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
    end

    @(posedge clk);
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/risc_v_id_ex.md
Name: risc_v_id_ex

Overview:
- ID/EX pipeline boundary of the 5-stage RISC-V core; sits directly downstream of the IF/ID pair and consumes its decoded outputs.
- Decodes main control from OPCODE_ID and registers operands plus control into the EX stage.
- Detects load-use hazards and drives PC_write/IF_ID_write back upstream; inserts a bubble on hazard or branch flush.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
COUNT_W, 16, width of the STALL_COUNT performance counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
PCSrc  input  1  taken branch resolved downstream; flush request
PC_ID  input  32  PC of the instruction in ID
IMM_ID  input  32  sign-extended immediate
REG_DATA1_ID  input  32  rs1 read data
REG_DATA2_ID  input  32  rs2 read data
FUNCT3_ID  input  3  funct3
FUNCT7_ID  input  7  funct7
OPCODE_ID  input  7  opcode
RD_ID, RS1_ID, RS2_ID  input  5 each  register indices
PC_write  output  1  PC enable to IF (combinational)
IF_ID_write  output  1  IF/ID register enable (combinational)
IF_ID_flush  output  1  clears IF/ID register (combinational, = PCSrc)
PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX  output  32 each  registered operands
FUNCT3_EX  output  3; FUNCT7_EX  output  7  registered function fields
RD_EX, RS1_EX, RS2_EX  output  5 each  registered indices
RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX, Branch_EX  output  1 each  registered control
ALUOp_EX  output  2  registered ALU op class
STALL_COUNT  output  COUNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset, asynchronous: all EX outputs are 0 and STALL_COUNT is 0. PC_write=1, IF_ID_write=1, IF_ID_flush=0 while reset is held.
- Control decode is combinational from OPCODE_ID. Every unlisted opcode gives all-zero control.
  - 0110011 (R): RegWrite, ALUOp=10.
  - 0010011 (I-ALU): RegWrite, ALUSrc, ALUOp=10.
  - 0000011 (load): RegWrite, MemtoReg, MemRead, ALUSrc, ALUOp=00.
  - 0100011 (store): MemWrite, ALUSrc, ALUOp=00.
  - 1100011 (branch): Branch, ALUOp=01.
- uses_rs2 is 1 for R, store and branch opcodes.
- hazard = MemRead_EX & (RD_EX!=0) & ((RD_EX==RS1_ID) | (uses_rs2 & RD_EX==RS2_ID)).
- Upstream enables are combinational:
  - PC_write = IF_ID_write = ~(hazard & ~PCSrc).
  - IF_ID_flush = PCSrc.
- Each rising edge (latency 1):
  - All data and index fields load from their ID inputs unconditionally.
  - Control fields load the decoded value, except bubble = hazard | PCSrc forces all control bits and ALUOp to 0.
- A bubble clears MemRead_EX, so a load-use stall lasts exactly one cycle. Back-to-back stalls are impossible.
- PCSrc and hazard in the same cycle: flush wins. Bubble is inserted, PC_write and IF_ID_write stay 1, and STALL_COUNT does not increment.
- STALL_COUNT increments by 1 on each edge where hazard & ~PCSrc. It saturates at 2^COUNT_W-1 and never wraps.
- Reset asserted mid-stall forces the bubble state immediately. The first post-reset edge loads normally.
- Writes to x0 never trigger a hazard (RD_EX==0 excluded).

Test Plan:
- Reset check: assert reset mid-run -> all EX outputs 0, STALL_COUNT=0, PC_write=1 without waiting for clk.
- Decode sweep: present R, I-ALU, load, store, branch and 1111111 opcodes with PCSrc=0.
  - Next-cycle control bits match the decode list exactly.
  - The 1111111 opcode gives all-zero control.
- Load-use stall:
  - Stimulus: lw x5 in ID, then add x6,x5,x1 in ID.
  - Cycle 2: PC_write=0, IF_ID_write=0.
  - Cycle 3: EX control all 0, STALL_COUNT=1.
  - Cycle 4: add appears in EX with RegWrite_EX=1.
- No false hazard:
  - lw x0 followed by add x6,x0,x0 -> no stall.
  - lw x5 followed by addi x6,x7,1 where RS2_ID field=5 (I-type) -> no stall.
- Flush priority: hazard condition plus PCSrc=1 in the same cycle -> PC_write=1, IF_ID_flush=1, next EX control 0, STALL_COUNT unchanged.
- Saturation: COUNT_W=2, force 5 stall cycles -> STALL_COUNT reads 1,2,3,3,3.
